card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer_pkg.sv | 36 +++
 rtl/card_dealer_lfsr.sv | 36 +++
 rtl/card_dealer.sv | 192 +++++++++++++++++++
 tb/tb_card_dealer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_dealer_pkg.sv
// Shared card encoding, FSM state type and rank scoring helper for the card dealer.
package card_dealer_pkg;

  typedef logic [5:0] card_id_t;

  localparam int         DECK_SIZE  = 52;
  localparam int         RANK_COUNT = 13;
  localparam logic [3:0] RANK_ACE   = 4'd0;
  localparam logic [3:0] RANK_JACK  = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_PROBE,
    ST_PLACE,
    ST_SCORE
  } state_t;

  function automatic logic [3:0] rank_of(input card_id_t id);
    return 4'(id % 6'(RANK_COUNT));
  endfunction

  // Aces count high here; the dealer reduces them when the hand would bust.
  function automatic logic [3:0] rank_points(input card_id_t id);
    logic [3:0] r;
    r = rank_of(id);
    if (r == RANK_ACE) begin
      return 4'd11;
    end else if (r >= RANK_JACK) begin
      return 4'd10;
    end else begin
      return r + 4'd1;
    end
  endfunction

endpackage

// File: rtl/card_dealer_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random card draws.
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [15:0] value,
  output logic [15:0] value_next
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign value_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign value      = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (step) begin
      lfsr_d = value_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Blackjack card dealer: draws or places requested cards into a hand and scores it.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int          MAX_CARDS = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       deal_req,
  input  logic       preset_en,
  input  logic [5:0] preset_id,
  output logic       deal_done,
  output logic       deal_err,
  output logic       busy,
  output logic [5:0] card_id  [0:MAX_CARDS-1],
  output logic       card_vld [0:MAX_CARDS-1],
  output logic [3:0] card_count,
  output logic [6:0] hand_points,
  output logic       bust
);

  state_t         state_q, state_d;
  card_id_t       idx_q, idx_d;
  logic [51:0]    used_q, used_d;
  card_id_t       card_id_q  [0:MAX_CARDS-1];
  card_id_t       card_id_d  [0:MAX_CARDS-1];
  logic           card_vld_q [0:MAX_CARDS-1];
  logic           card_vld_d [0:MAX_CARDS-1];
  logic [3:0]     card_count_q, card_count_d;
  logic [6:0]     hand_points_q, hand_points_d;
  logic           bust_q, bust_d;
  logic           deal_done_q, deal_done_d;
  logic           deal_err_q, deal_err_d;

  logic           lfsr_load, lfsr_step;
  logic [15:0]    lfsr_value, lfsr_next;
  logic           lfsr_unused;
  logic [7:0]     score_total;
  logic [3:0]     score_aces;

  card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (lfsr_load),
    .step       (lfsr_step),
    .value      (lfsr_value),
    .value_next (lfsr_next)
  );

  // Only the low six bits of the stepped value pick a card.
  assign lfsr_unused = ^{lfsr_value, lfsr_next[15:6]};

  // Hand score: aces start at 11 and drop to 1 one at a time while over 21.
  always_comb begin
    score_total = '0;
    score_aces  = '0;
    for (int i = 0; i < MAX_CARDS; i++) begin
      if (card_vld_q[i]) begin
        score_total = score_total + {4'd0, rank_points(card_id_q[i])};
        if (rank_of(card_id_q[i]) == RANK_ACE) begin
          score_aces = score_aces + 4'd1;
        end
      end
    end
    for (int i = 0; i < MAX_CARDS; i++) begin
      if (score_total > 8'd21 && score_aces != 4'd0) begin
        score_total = score_total - 8'd10;
        score_aces  = score_aces - 4'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    used_d        = used_q;
    card_id_d     = card_id_q;
    card_vld_d    = card_vld_q;
    card_count_d  = card_count_q;
    hand_points_d = hand_points_q;
    bust_d        = bust_q;
    deal_done_d   = 1'b0;
    deal_err_d    = 1'b0;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;

    if (new_game) begin
      state_d       = ST_IDLE;
      used_d        = '0;
      card_count_d  = '0;
      hand_points_d = '0;
      bust_d        = 1'b0;
      lfsr_load     = 1'b1;
      for (int i = 0; i < MAX_CARDS; i++) begin
        card_id_d[i]  = '0;
        card_vld_d[i] = 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (deal_req) begin
            if (card_count_q == 4'(MAX_CARDS)) begin
              deal_err_d = 1'b1;
            end else if (preset_en) begin
              if (preset_id < 6'(DECK_SIZE)) begin
                idx_d   = preset_id;
                state_d = ST_PROBE;
              end else begin
                deal_err_d = 1'b1;
              end
            end else begin
              state_d = ST_DRAW;
            end
          end
        end
        ST_DRAW: begin
          lfsr_step = 1'b1;
          if (lfsr_next[5:0] < 6'(DECK_SIZE)) begin
            idx_d   = lfsr_next[5:0];
            state_d = ST_PROBE;
          end
        end
        ST_PROBE: begin
          // Linear probe wraps 51 -> 0; the deck never fills so this ends.
          if (used_q[idx_q]) begin
            idx_d = (idx_q == 6'(DECK_SIZE - 1)) ? '0 : idx_q + 6'd1;
          end else begin
            state_d = ST_PLACE;
          end
        end
        ST_PLACE: begin
          for (int i = 0; i < MAX_CARDS; i++) begin
            if (card_count_q == 4'(i)) begin
              card_id_d[i]  = idx_q;
              card_vld_d[i] = 1'b1;
            end
          end
          used_d[idx_q] = 1'b1;
          card_count_d  = card_count_q + 4'd1;
          state_d       = ST_SCORE;
        end
        ST_SCORE: begin
          hand_points_d = score_total[6:0];
          bust_d        = score_total > 8'd21;
          deal_done_d   = 1'b1;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      used_q        <= '0;
      card_count_q  <= '0;
      hand_points_q <= '0;
      bust_q        <= 1'b0;
      deal_done_q   <= 1'b0;
      deal_err_q    <= 1'b0;
      for (int i = 0; i < MAX_CARDS; i++) begin
        card_id_q[i]  <= '0;
        card_vld_q[i] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      used_q        <= used_d;
      card_count_q  <= card_count_d;
      hand_points_q <= hand_points_d;
      bust_q        <= bust_d;
      deal_done_q   <= deal_done_d;
      deal_err_q    <= deal_err_d;
      card_id_q     <= card_id_d;
      card_vld_q    <= card_vld_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign deal_done   = deal_done_q;
  assign deal_err    = deal_err_q;
  assign card_id     = card_id_q;
  assign card_vld    = card_vld_q;
  assign card_count  = card_count_q;
  assign hand_points = hand_points_q;
  assign bust        = bust_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed vector table, corner sequences, random stress vs a hand model.
module tb_card_dealer;

  localparam int          MAX_CARDS = 9;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       new_game = 1'b0;
  logic       deal_req = 1'b0;
  logic       preset_en = 1'b0;
  logic [5:0] preset_id = '0;
  logic       deal_done, deal_err, busy, bust;
  logic [5:0] card_id  [0:MAX_CARDS-1];
  logic       card_vld [0:MAX_CARDS-1];
  logic [3:0] card_count;
  logic [6:0] hand_points;

  always #5 clk = ~clk;

  card_dealer #(.MAX_CARDS(MAX_CARDS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .deal_req(deal_req),
    .preset_en(preset_en), .preset_id(preset_id), .deal_done(deal_done),
    .deal_err(deal_err), .busy(busy), .card_id(card_id), .card_vld(card_vld),
    .card_count(card_count), .hand_points(hand_points), .bust(bust)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the hand as a list of ids, a used-card table and the LFSR value.
  bit          m_used [52];
  int          m_hand [$];
  logic [15:0] m_lfsr;

  typedef struct {
    bit ng; bit pen; int id;
    bit exp_err; int exp_card; int exp_lat; int exp_pts; bit exp_bust; int exp_cnt;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    logic fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return {x[14:0], fb};
  endfunction

  function automatic int card_value(input int id);
    int r;
    r = id % 13;
    if (r == 0) return 11;
    if (r >= 10) return 10;
    return r + 1;
  endfunction

  function automatic int model_points();
    int total, aces;
    total = 0; aces = 0;
    foreach (m_hand[i]) begin
      total += card_value(m_hand[i]);
      if (m_hand[i] % 13 == 0) aces++;
    end
    while (total > 21 && aces > 0) begin
      total -= 10; aces--;
    end
    return total;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
    m_hand.delete();
    m_lfsr = SEED;
  endtask

  task automatic do_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    model_clear();
    check("ng_count", int'(card_count), 0);
  endtask

  // One deal request; compares against the model and reports what the DUT did.
  task automatic do_deal(input bit pen, input int id, output bit got_err, output int got_lat);
    bit exp_err;
    int e, skips, draws, exp_lat, pts, slot;
    bit done;
    exp_err = 1'b0; e = 0; skips = 0; draws = 0; exp_lat = 0;
    if (m_hand.size() == MAX_CARDS) begin
      exp_err = 1'b1;
    end else if (pen && id >= 52) begin
      exp_err = 1'b1;
    end else begin
      if (pen) begin
        e = id;
      end else begin
        do begin
          m_lfsr = lfsr_adv(m_lfsr);
          draws++;
        end while (int'(m_lfsr[5:0]) >= 52);
        e = int'(m_lfsr[5:0]);
      end
      while (m_used[e]) begin
        e = (e + 1) % 52;
        skips++;
      end
      exp_lat = draws + skips + 3;
    end

    @(negedge clk); deal_req = 1'b1; preset_en = pen; preset_id = 6'(id);
    @(negedge clk); deal_req = 1'b0; preset_en = 1'b0;
    got_err = deal_err;
    got_lat = -1;
    done = 1'b0;
    if (!got_err) begin
      for (int n = 1; n <= 200 && !done; n++) begin
        @(negedge clk);
        if (deal_done) begin
          done = 1'b1;
          got_lat = n;
        end
      end
    end

    check("m_err", int'(got_err), int'(exp_err));
    if (!exp_err) begin
      m_hand.push_back(e);
      m_used[e] = 1'b1;
      pts  = model_points();
      slot = m_hand.size() - 1;
      check("m_latency", got_lat, exp_lat);
      check("m_card_id", int'(card_id[slot]), e);
      check("m_card_vld", int'(card_vld[slot]), 1);
      check("m_count", int'(card_count), m_hand.size());
      check("m_points", int'(hand_points), pts);
      check("m_bust", int'(bust), int'(pts > 21));
    end else begin
      check("m_err_count", int'(card_count), m_hand.size());
    end
  endtask

  task automatic check_no_dup();
    int dups;
    dups = 0;
    for (int i = 0; i < MAX_CARDS; i++)
      for (int j = i + 1; j < MAX_CARDS; j++)
        if (card_vld[i] && card_vld[j] && card_id[i] == card_id[j]) dups++;
    check("no_dup", dups, 0);
  endtask

  task automatic check_cleared(input string name);
    int vld_or, id_or;
    vld_or = 0; id_or = 0;
    for (int i = 0; i < MAX_CARDS; i++) begin
      vld_or |= int'(card_vld[i]);
      id_or  |= int'(card_id[i]);
    end
    check({name, "_vld"}, vld_or, 0);
    check({name, "_ids"}, id_or, 0);
    check({name, "_count"}, int'(card_count), 0);
    check({name, "_points"}, int'(hand_points), 0);
    check({name, "_bust"}, int'(bust), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(deal_done), 0);
  endtask

  initial begin
    bit err;
    int lat, seen;

    tbl[0] = '{1, 1, 0,  0, 0,  3, 11, 0, 1};
    tbl[1] = '{0, 1, 12, 0, 12, 3, 21, 0, 2};
    tbl[2] = '{1, 1, 0,  0, 0,  3, 11, 0, 1};
    tbl[3] = '{0, 1, 13, 0, 13, 3, 12, 0, 2};
    tbl[4] = '{0, 1, 26, 0, 26, 3, 13, 0, 3};
    tbl[5] = '{1, 1, 9,  0, 9,  3, 10, 0, 1};
    tbl[6] = '{0, 1, 10, 0, 10, 3, 20, 0, 2};
    tbl[7] = '{0, 1, 9,  0, 11, 5, 30, 1, 3};
    tbl[8] = '{0, 1, 60, 1, 0,  0, 30, 1, 3};

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    check("reset_err", int'(deal_err), 0);
    rst = 1'b1;
    model_clear();

    // Directed preset vectors
    for (int k = 0; k < 9; k++) begin
      if (tbl[k].ng) do_new_game();
      do_deal(tbl[k].pen, tbl[k].id, err, lat);
      check($sformatf("tbl%0d_err", k), int'(err), int'(tbl[k].exp_err));
      if (!tbl[k].exp_err) begin
        check($sformatf("tbl%0d_lat", k), lat, tbl[k].exp_lat);
        check($sformatf("tbl%0d_card", k), int'(card_id[tbl[k].exp_cnt - 1]), tbl[k].exp_card);
      end
      check($sformatf("tbl%0d_pts", k), int'(hand_points), tbl[k].exp_pts);
      check($sformatf("tbl%0d_bust", k), int'(bust), int'(tbl[k].exp_bust));
      check($sformatf("tbl%0d_cnt", k), int'(card_count), tbl[k].exp_cnt);
    end

    // Full hand, then refused deals
    do_new_game();
    for (int k = 0; k < MAX_CARDS; k++) do_deal(k[0], 4 * k, err, lat);
    check("full_count", int'(card_count), 9);
    do_deal(1'b0, 0, err, lat);
    check("full_err_rand", int'(err), 1);
    do_deal(1'b1, 50, err, lat);
    check("full_err_preset", int'(err), 1);
    check("full_count_after", int'(card_count), 9);
    check_no_dup();

    // new_game while in PROBE abandons the deal
    do_new_game();
    do_deal(1'b1, 5, err, lat);
    do_deal(1'b1, 6, err, lat);
    @(negedge clk); deal_req = 1'b1; preset_en = 1'b1; preset_id = 6'd5;
    @(negedge clk); deal_req = 1'b0; preset_en = 1'b0;
    check("probe_busy", int'(busy), 1);
    new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    check_cleared("ng_probe");
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= int'(deal_done);
    end
    check("ng_probe_no_done", seen, 0);
    model_clear();
    do_deal(1'b0, 0, err, lat);

    // Reset mid-deal abandons the deal
    @(negedge clk); deal_req = 1'b1; preset_en = 1'b1; preset_id = 6'd20;
    @(negedge clk); deal_req = 1'b0; preset_en = 1'b0; rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check_cleared("rst_mid");
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= int'(deal_done);
    end
    check("rst_mid_no_done", seen, 0);
    model_clear();
    do_deal(1'b0, 0, err, lat);
    do_deal(1'b0, 0, err, lat);

    // Random stress: mixed random and preset deals over many games
    for (int g = 0; g < 12; g++) begin
      do_new_game();
      for (int a = 0; a < 30 && m_hand.size() < MAX_CARDS; a++) begin
        do_deal(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), err, lat);
        check_no_dup();
      end
      do_deal(1'($urandom_range(0, 1)), int'($urandom_range(0, 51)), err, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
